// File: rtl/jt49_decim.sv
// jt49_decim: decimating pre-stage ahead of the JT49 moving averager.
// Converts the offset-binary mixer sample to two's complement and averages
// blocks of 2^rw accepted samples. Each block produces one signed sample and
// a one-clk strobe.
//
// Ports:
//   clk     system clock
//   rst     asynchronous, active-low reset
//   cen     input sample strobe (one sample per clk edge with cen=1)
//   din     unsigned offset-binary sample, win bits
//   dout    signed decimated sample, dw bits (holds between strobes)
//   cen_out one-clk pulse marking a new dout (drives the averager's cen)
//
// Build option: define JT49_DECIM_ROUND_EN to round half up, with positive
// saturation, instead of truncating when win > dw.
module jt49_decim #(
  parameter int unsigned win = 10,
  parameter int unsigned dw  = 8,
  parameter int unsigned rw  = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cen,
  input  logic [win-1:0] din,
  output logic [dw-1:0]  dout,
  output logic           cen_out
);

  localparam int unsigned AW = win + rw;

  logic [win-1:0] s;
  logic [AW-1:0]  acc;
  logic [AW-1:0]  sum;
  logic [rw-1:0]  cnt;
  logic           close;
  logic [dw-1:0]  dout_nxt;

  // Flipping the MSB converts offset binary to two's complement.
  assign s     = {~din[win-1], din[win-2:0]};
  assign sum   = acc + {{rw{s[win-1]}}, s};
  assign close = cen && (cnt == {rw{1'b1}});

  // The top win bits of sum are (sum >>> rw), so its top dw bits are the
  // truncated output.
`ifdef JT49_DECIM_ROUND_EN
  generate
    if (win > dw) begin : g_round
      localparam int unsigned RW1 = dw + 1;
      logic [dw:0] t;
      logic [dw:0] r;
      // t keeps one extra bit below the output LSB; adding it back after
      // halving rounds half up.
      always_comb begin
        t = sum[AW-1 -: RW1];
        r = {t[dw], t[dw:1]} + RW1'(t[0]);
        if (!r[dw] && r[dw-1]) dout_nxt = {1'b0, {(dw-1){1'b1}}};
        else                   dout_nxt = r[dw-1:0];
      end
    end else begin : g_pass
      assign dout_nxt = sum[AW-1 -: dw];
    end
  endgenerate
`else
  assign dout_nxt = sum[AW-1 -: dw];
`endif

  // Window counter, accumulator and output register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      acc     <= '0;
      dout    <= '0;
      cen_out <= 1'b0;
    end else begin
      cen_out <= 1'b0;
      if (cen) begin
        if (close) begin
          acc     <= '0;
          cnt     <= '0;
          dout    <= dout_nxt;
          cen_out <= 1'b1;
        end else begin
          acc <= sum;
          cnt <= cnt + rw'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_jt49_decim.sv
// Self-checking bench for jt49_decim (win=10, dw=8, rw=3).
// The reference model keeps the accepted samples of the open window in a
// queue. It computes each block average with integer floor division.
module tb_jt49_decim;

  localparam int R = 8;

  logic       clk;
  logic       rst;
  logic       cen;
  logic [9:0] din;
  logic [7:0] dout;
  logic       cen_out;

  int checks;
  int errors;

  int         q[$];
  logic [7:0] exp_dout;

  jt49_decim #(.win(10), .dw(8), .rw(3)) dut (
    .clk(clk), .rst(rst), .cen(cen), .din(din), .dout(dout), .cen_out(cen_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int floordiv(int a, int b);
    if (a >= 0) return a / b;
    return -((-a + b - 1) / b);
  endfunction

  // Expected output for a window whose signed samples add up to sum.
  function automatic logic [7:0] model(int sum);
    int avg;
    int r;
    avg = floordiv(sum, R);
`ifdef JT49_DECIM_ROUND_EN
    r = floordiv(avg + 2, 4);
    if (r > 127) r = 127;
`else
    r = floordiv(avg, 4);
`endif
    return 8'(r);
  endfunction

  // Applies one clock of stimulus and advances the model.
  // On entry and on exit the bench is 1 time unit after a rising edge.
  task automatic drive(input logic c, input logic [9:0] d,
                       output logic ep, output logic [7:0] ed);
    int sum;
    cen = c;
    din = d;
    @(posedge clk);
    #1;
    ep = 1'b0;
    if (c) q.push_back(int'(d) - 512);
    if (q.size() == R) begin
      sum = 0;
      foreach (q[i]) sum += q[i];
      exp_dout = model(sum);
      q.delete();
      ep = 1'b1;
    end
    ed = exp_dout;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    q.delete();
    exp_dout = 8'h00;
    for (int i = 0; i < 6; i++) begin
      cen = 1'($urandom_range(0, 1));
      din = 10'($urandom);
      @(posedge clk);
      #1;
      checks++;
      if (dout !== 8'h00 || cen_out !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d dout=%h cen_out=%b want dout=00 cen_out=0",
                 i, dout, cen_out);
      end
    end
    rst = 1'b1;
  endtask

  task automatic run_const(input string name, input logic [9:0] d,
                           input logic [7:0] want);
    logic ep;
    logic [7:0] ed;
    for (int i = 0; i < R; i++) begin
      drive(1'b1, d, ep, ed);
      checks++;
      if (cen_out !== ep || (ep && dout !== ed)) begin
        errors++;
        $display("FAIL %s cen=%0d cen_out=%b dout=%h want cen_out=%b dout=%h",
                 name, i + 1, cen_out, dout, ep, ed);
      end
    end
    checks++;
    if (dout !== want) begin
      errors++;
      $display("FAIL %s_const dout=%h want %h", name, dout, want);
    end
  endtask

  task automatic test_midscale();
    logic ep;
    logic [7:0] ed;
    int first;
    int second;
    first  = -1;
    second = -1;
    for (int i = 0; i < 2 * R; i++) begin
      drive(1'b1, 10'h200, ep, ed);
      if (cen_out === 1'b1) begin
        if (first < 0) first = i;
        else if (second < 0) second = i;
      end
      checks++;
      if (cen_out !== ep || (ep && dout !== ed) || dout !== 8'h00) begin
        errors++;
        $display("FAIL midscale clk=%0d cen_out=%b dout=%h want cen_out=%b dout=00",
                 i, cen_out, dout, ep);
      end
    end
    checks++;
    if (first != 7 || second != 15) begin
      errors++;
      $display("FAIL midscale_period pulses at %0d,%0d want 7,15", first, second);
    end
  endtask

  task automatic test_full_scale();
    run_const("full_pos", 10'h3FF, 8'h7F);
    run_const("full_neg", 10'h000, 8'h80);
  endtask

  task automatic test_rounding();
`ifdef JT49_DECIM_ROUND_EN
    run_const("rounding", 10'h206, 8'h02);
`else
    run_const("rounding", 10'h206, 8'h01);
`endif
  endtask

  task automatic test_sparse_alternating();
    logic ep;
    logic [7:0] ed;
    logic c;
    int k;
    int pulses;
    k = 0;
    pulses = 0;
    for (int i = 0; i < 3 * R; i++) begin
      c = (i % 3 == 2);
      drive(c, (k % 2 == 0) ? 10'h300 : 10'h100, ep, ed);
      if (c) k++;
      if (cen_out === 1'b1) pulses++;
      checks++;
      if (cen_out !== ep || (ep && dout !== ed)) begin
        errors++;
        $display("FAIL sparse clk=%0d cen_out=%b dout=%h want cen_out=%b dout=%h",
                 i, cen_out, dout, ep, ed);
      end
    end
    checks++;
    if (pulses != 1 || dout !== 8'h00) begin
      errors++;
      $display("FAIL sparse_count pulses=%0d dout=%h want 1 pulse dout=00", pulses, dout);
    end
  endtask

  task automatic test_reset_mid_window();
    logic ep;
    logic [7:0] ed;
    for (int i = 0; i < 5; i++) drive(1'b1, 10'h3FF, ep, ed);
    rst = 1'b0;
    q.delete();
    exp_dout = 8'h00;
    #1;
    checks++;
    if (dout !== 8'h00 || cen_out !== 1'b0) begin
      errors++;
      $display("FAIL async_reset dout=%h cen_out=%b want 00/0", dout, cen_out);
    end
    for (int i = 0; i < 2; i++) begin
      cen = 1'b1;
      @(posedge clk);
    end
    #1;
    rst = 1'b1;
    run_const("post_reset", 10'h280, 8'h20);
  endtask

  task automatic test_random();
    logic ep;
    logic [7:0] ed;
    logic c;
    for (int i = 0; i < 300; i++) begin
      c = ($urandom_range(0, 3) != 0);
      drive(c, 10'($urandom), ep, ed);
      checks++;
      if (cen_out !== ep || dout !== ed) begin
        errors++;
        $display("FAIL random clk=%0d cen_out=%b dout=%h want cen_out=%b dout=%h",
                 i, cen_out, dout, ep, ed);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    cen = 1'b0;
    din = 10'h200;
    exp_dout = 8'h00;
    @(posedge clk);
    #1;
    test_reset();
    test_midscale();
    test_full_scale();
    test_rounding();
    test_sparse_alternating();
    test_reset_mid_window();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jt49_decim.md
Name: jt49_decim

Overview:
- Decimating pre-stage that sits directly upstream of the moving averager in the JT49 output filter chain.
- Takes the unsigned offset-binary mixer sample at the chip sample rate and converts it to two's complement.
- Block-averages 2^rw consecutive samples and emits one signed sample per window, together with a single-cycle strobe that drives the moving averager's cen.

Parameters:
- win, 10, input sample width (unsigned, offset binary); win >= dw required
- dw, 8, output sample width (signed); must equal the downstream averager's dw
- rw, 3, log2 of the decimation ratio R = 2^rw; rw >= 1 required

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- cen  in  1  input sample strobe; one sample accepted per clk edge with cen=1
- din  in  win  unsigned mixer sample, offset binary (mid-scale = 2^(win-1))
- dout  out  dw  signed decimated sample
- cen_out  out  1  one-clk pulse marking a new dout; connects to the averager's cen

Behaviour:
- Reset (rst=0, asynchronous): cnt=0, acc=0, dout=0, cen_out=0. Any partial window is discarded. The first window after release starts on the first cen.
- Sign conversion (combinational): s = {~din[win-1], din[win-2:0]}, a signed win-bit value.
- Window counter cnt: rw bits, increments on every cen, wraps from R-1 to 0. It holds when cen=0.
- Accumulator acc: signed, win+rw bits, so it cannot overflow for R samples.
- cen=1 and cnt<R-1: acc <= acc + s.
- cen=1 and cnt==R-1 (window close):
  - avg = (acc + s) >>> rw, arithmetic shift giving signed win bits.
  - acc <= 0; cnt <= 0.
  - dout <= avg[win-1 -: dw] (truncation toward -inf).
  - cen_out <= 1.
- cen_out is 1 for exactly the one clk period after the closing edge. It is 0 on every other edge, including edges where cen=0.
- Latency: dout and cen_out update on the same edge that samples the R-th cen of the window. The downstream stage samples both on the following edge.
- Continuous cen=1: cen_out pulses every R clocks. Sparse cen: pulse rate = cen rate / R. Clock cycles without cen do not count toward the window.
- dout holds its value between pulses.
- cen_out never asserts twice within one window and never asserts without a preceding close.
- No input backpressure; every cen sample is consumed.

Optional Feature:
- Macro JT49_DECIM_ROUND_EN.
- Defined, with win > dw:
  - Before slicing, add 2^(win-dw-1) to avg in a (win+1)-bit signed intermediate (round half up).
  - If the result exceeds 2^(win-1)-1, dout saturates to the maximum positive value (0111...1).
  - Negative results cannot overflow.
- Defined, with win == dw: no-op.
- Not defined: plain truncation as in Behaviour, and no saturation logic is generated.

Test Plan (win=10, dw=8, rw=3):
- Reset: hold rst=0 with clocks and cen toggling -> dout=8'h00 and cen_out=0 throughout. After release, cen_out stays 0 until the 8th cen.
- Mid-scale: din=10'h200 for 8 cen (cen=1 continuously) -> exactly one cen_out pulse, on the edge of the 8th cen, with dout=8'h00. The pulse repeats every 8 clocks.
- Full scale: din=10'h3FF (s=+511) for 8 cen -> dout=8'h7F. With ROUND_EN: 511+2 overflows, so dout saturates to 8'h7F.
- Negative full scale: din=10'h000 (s=-512) for 8 cen -> dout=8'h80.
- Rounding: din=10'h206 (s=+6) for 8 cen -> dout=8'h01 without ROUND_EN, 8'h02 with it.
- Alternating and reset mid-window:
  - Alternate 10'h300/10'h100 for 8 cen, with cen=1 every 3rd clk -> dout=8'h00 and cen_out pulses once per 24 clks.
  - Then apply 5 cen of 10'h3FF, assert rst for 2 clks, then 8 cen of 10'h280 (s=+128) -> no pulse before the 8th post-reset cen, then dout=8'h20.
